// File: rtl/sdp_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sdp_fifo_ctrl
// Single-clock FIFO built on a simple-dual-port storage array. Writes enter
// through a valid/ready sink. Reads leave through a first-word-fall-through
// valid/ready source whose data register is the registered RAM read output.
//
// Ports:
//   clk      in   clock, all logic on the rising edge
//   rst_n    in   synchronous active-low reset
//   s_valid  in   producer write request
//   s_ready  out  FIFO can accept a word (registered, = !full)
//   s_data   in   write data [DW-1:0]
//   m_valid  out  m_data holds the head word
//   m_ready  in   consumer takes the head word
//   m_data   out  head word [DW-1:0], registered RAM read output
//   count    out  words held, RAM plus output register [AW:0]
//   full     out  count == 2**AW
//   empty    out  count == 0
// -----------------------------------------------------------------------------
module sdp_fifo_ctrl #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 2 ** AW;
    localparam int CW    = AW + 1;

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

    logic [DW-1:0] mem_r [DEPTH];

    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [CW-1:0] ram_cnt_r;
    logic [CW-1:0] count_r;
    logic          m_valid_r;
    logic [DW-1:0] m_data_r;
    logic          full_r;
    logic          empty_r;
    logic          s_ready_r;

    logic          wen_s;
    logic          ren_s;
    logic [CW-1:0] ram_cnt_next_s;
    logic          m_valid_next_s;
    logic [CW-1:0] count_next_s;

    // Port strobes: write when the sink handshake fires. Read the RAM whenever
    // it holds a word and the output register is empty or being emptied. The
    // two cannot address the same slot in one cycle: a read needs ram_cnt != 0
    // and a write needs count < DEPTH.
    always_comb begin
        wen_s = s_valid & s_ready_r;
        ren_s = (ram_cnt_r != CNT_ZERO) & (~m_valid_r | m_ready);
    end

    // Next occupancy and output-valid state. The flags are registered from
    // these so s_ready has no combinational path from m_ready.
    always_comb begin
        ram_cnt_next_s = ram_cnt_r;
        case ({wen_s, ren_s})
            2'b10:   ram_cnt_next_s = ram_cnt_r + CNT_ONE;
            2'b01:   ram_cnt_next_s = ram_cnt_r - CNT_ONE;
            default: ram_cnt_next_s = ram_cnt_r;
        endcase

        m_valid_next_s = m_valid_r;
        if (ren_s) begin
            m_valid_next_s = 1'b1;
        end else if (m_ready) begin
            m_valid_next_s = 1'b0;
        end else begin
            m_valid_next_s = m_valid_r;
        end

        count_next_s = ram_cnt_next_s + CW'(m_valid_next_s);
    end

    // Storage array write port; contents are never reset and writes are
    // suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && wen_s) begin
            mem_r[wptr_r] <= s_data;
        end
    end

    // Pointers, occupancy, output register and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_r    <= PTR_ZERO;
            rptr_r    <= PTR_ZERO;
            ram_cnt_r <= CNT_ZERO;
            count_r   <= CNT_ZERO;
            m_valid_r <= 1'b0;
            m_data_r  <= DATA_ZERO;
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            s_ready_r <= 1'b1;
        end else begin
            if (wen_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (ren_s) begin
                rptr_r   <= rptr_r + PTR_ONE;
                m_data_r <= mem_r[rptr_r];
            end
            ram_cnt_r <= ram_cnt_next_s;
            m_valid_r <= m_valid_next_s;
            count_r   <= count_next_s;
            full_r    <= (count_next_s == DEPTH_CNT);
            empty_r   <= (count_next_s == CNT_ZERO);
            s_ready_r <= (count_next_s != DEPTH_CNT);
        end
    end

    assign s_ready = s_ready_r;
    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign count   = count_r;
    assign full    = full_r;
    assign empty   = empty_r;

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdp_fifo_ctrl
// Self-checking bench for sdp_fifo_ctrl (AW=4, DW=4). Accepted words are
// pushed to a scoreboard queue and popped when the consumer handshake fires.
// Occupancy and flags are checked against the queue depth every cycle.
// -----------------------------------------------------------------------------
module tb_sdp_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int            n_cmp;
    int            n_err;
    int            n_wr;
    logic [DW-1:0] sb[$];
    logic          prev_hold;
    logic [DW-1:0] prev_data;

    sdp_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: act=%0h req=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle; called at a falling edge, returns at the next one.
    task automatic cycle(input logic sv, input logic [DW-1:0] sd, input logic mr);
        logic exp_rdy;
        logic rd;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
        exp_rdy = (sb.size() < DEPTH);
        chk("s_ready", {31'd0, s_ready}, {31'd0, exp_rdy});
        chk("count", {27'd0, count}, sb.size());
        chk("full", {31'd0, full}, {31'd0, sb.size() == DEPTH});
        chk("empty", {31'd0, empty}, {31'd0, sb.size() == 0});
        if (prev_hold) begin
            chk("hold_valid", {31'd0, m_valid}, 32'd1);
            chk("hold_data", {28'd0, m_data}, {28'd0, prev_data});
        end
        rd = m_valid && mr;
        if (rd) begin
            if (sb.size() == 0) begin
                chk("underflow", {31'd0, m_valid}, 32'd0);
            end else begin
                chk("m_data", {28'd0, m_data}, {28'd0, sb.pop_front()});
            end
        end
        if (sv && exp_rdy) begin
            sb.push_back(sd);
            n_wr++;
        end
        prev_hold = m_valid && !mr;
        prev_data = m_data;
        @(negedge clk);
    endtask

    // Hold reset for n edges with the given write request, checking reset state.
    task automatic reset_phase(input int n, input logic sv, input logic [DW-1:0] sd);
        rst_n   = 1'b0;
        s_valid = sv;
        s_data  = sd;
        m_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst_count", {27'd0, count}, 32'd0);
            chk("rst_empty", {31'd0, empty}, 32'd1);
            chk("rst_full", {31'd0, full}, 32'd0);
            chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
            chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
            chk("rst_m_data", {28'd0, m_data}, 32'd0);
        end
        sb.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    // Read until the scoreboard empties; a bound expiry shows up as a failure.
    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            cycle(1'b0, 4'h0, 1'b1);
        end
        chk("drained", sb.size(), 32'd0);
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_m_valid", {31'd0, m_valid}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] d;
        n_cmp     = 0;
        n_err     = 0;
        n_wr      = 0;
        prev_hold = 1'b0;
        prev_data = 4'h0;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = 4'h0;
        m_ready   = 1'b0;
        @(negedge clk);

        // Reset with a write request pending, then first-word latency.
        reset_phase(3, 1'b1, 4'hA);
        cycle(1'b1, 4'h3, 1'b0);
        chk("lat_e0_m_valid", {31'd0, m_valid}, 32'd0);
        cycle(1'b0, 4'h0, 1'b0);
        chk("lat_e1_m_valid", {31'd0, m_valid}, 32'd1);
        chk("lat_e1_m_data", {28'd0, m_data}, 32'd3);
        drain();

        // Fill to full with 1..15,1, try a 17th write, then drain back to back.
        for (int i = 0; i < DEPTH; i++) begin
            d = DW'((i % 15) + 1);
            cycle(1'b1, d, 1'b0);
        end
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_s_ready", {31'd0, s_ready}, 32'd0);
        cycle(1'b1, 4'h7, 1'b0);
        chk("ovf_count", {27'd0, count}, 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_seq_valid", {31'd0, m_valid}, 32'd1);
            cycle(1'b0, 4'h0, 1'b1);
        end
        chk("fill_drained_empty", {31'd0, empty}, 32'd1);
        chk("fill_drained_sb", sb.size(), 32'd0);

        // Streaming: continuous write and read, no gaps after fill latency.
        for (int i = 0; i < 40; i++) begin
            if (i >= 2) begin
                chk("stream_valid", {31'd0, m_valid}, 32'd1);
            end
            d = DW'(i);
            cycle(1'b1, d, 1'b1);
        end
        drain();

        // Backpressure: m_ready pattern 1,0,0,1 while writing 20 words.
        n_wr = 0;
        for (int i = 0; i < 200 && n_wr < 20; i++) begin
            d = DW'(i * 3 + 1);
            cycle(1'b1, d, ((i % 4) == 0) || ((i % 4) == 3));
            chk("bp_count_max", {31'd0, count <= 5'd16}, 32'd1);
        end
        chk("bp_words", n_wr, 32'd20);
        drain();

        // Full plus simultaneous read and write: only the read fires.
        for (int i = 0; i < DEPTH; i++) begin
            d = DW'(15 - i);
            cycle(1'b1, d, 1'b0);
        end
        chk("fr_full", {31'd0, full}, 32'd1);
        cycle(1'b1, 4'h9, 1'b1);
        chk("fr_count", {27'd0, count}, 32'd15);
        chk("fr_s_ready", {31'd0, s_ready}, 32'd1);
        drain();

        // Mid-operation reset with 9 words held, then a clean restart.
        for (int i = 0; i < 9; i++) begin
            d = DW'(i + 2);
            cycle(1'b1, d, 1'b0);
        end
        chk("mid_count", {27'd0, count}, 32'd9);
        chk("mid_m_valid", {31'd0, m_valid}, 32'd1);
        reset_phase(1, 1'b1, 4'hB);
        cycle(1'b1, 4'h5, 1'b0);
        chk("post_rst_e0_valid", {31'd0, m_valid}, 32'd0);
        cycle(1'b0, 4'h0, 1'b0);
        chk("post_rst_e1_valid", {31'd0, m_valid}, 32'd1);
        chk("post_rst_e1_data", {28'd0, m_data}, 32'd5);
        drain();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'h0, 1'b1);
            chk("no_stale", {31'd0, m_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
